// File: rtl/vm_pkg.sv
// Shared constants for the vending machine front-end: FSM states, pending-bit
// indices, coin values and the fixed-priority selector.
package vm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int unsigned IDX_C2  = 0;
   localparam int unsigned IDX_C5  = 1;
   localparam int unsigned IDX_C10 = 2;
   localparam int unsigned IDX_REF = 3;
   localparam int unsigned NUM_BTN = 4;

   localparam int unsigned COIN2_VAL  = 2;
   localparam int unsigned COIN5_VAL  = 5;
   localparam int unsigned COIN10_VAL = 10;

   // Lowest set index wins: coin2 > coin5 > coin10 > refund.
   function automatic logic [1:0] prio_sel(input logic [3:0] pend);
      prio_sel = 2'(IDX_REF);
      for (int i = 3; i >= 0; i--) begin
         if (pend[i]) prio_sel = 2'(i);
      end
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability counter and accepted level,
// with a strobe on the edge where the accepted level goes 0->1.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      accept   = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
            accept   = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = accept & sync2_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces the four coin/refund buttons into serialized single-cycle pulses
// and synchronizes the product switches.
module coin_input_conditioner
   import vm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned PULSE_GAP       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn2_raw,
   input  logic       btn5_raw,
   input  logic       btn10_raw,
   input  logic       btnrefund_raw,
   input  logic [2:0] sw_raw,
   output logic       coin2_pulse,
   output logic       coin5_pulse,
   output logic       coin10_pulse,
   output logic       refund_pulse,
   output logic [2:0] sw_sync,
   output logic       press_drop,
   output logic       busy
);

   localparam int unsigned GW = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;

   logic [NUM_BTN-1:0] raw_vec, btn_stable, btn_rise, press_set;
   logic [NUM_BTN-1:0] pending_q, pending_d, clr;
   logic [NUM_BTN-1:0] pulse_vec;
   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic               drop_q, drop_d, arb;
   logic [2:0]         sw1_q, sw2_q;

   assign raw_vec = {btnrefund_raw, btn10_raw, btn5_raw, btn2_raw};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .rst    (rst),
         .raw    (raw_vec[i]),
         .stable (btn_stable[i]),
         .rise   (btn_rise[i])
      );
   end

   assign press_set = btn_rise & ~btn_stable;

   // Arbitration happens in IDLE and on the last gap cycle, so pulses can run back to back.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      gap_cnt_d = gap_cnt_q;
      clr       = '0;
      arb       = 1'b0;
      case (state_q)
         IDLE: arb = 1'b1;
         EMIT: begin
            if (PULSE_GAP == 0) begin
               arb = 1'b1;
            end else begin
               state_d   = GAP;
               gap_cnt_d = '0;
            end
         end
         GAP: begin
            if (gap_cnt_q == GW'(PULSE_GAP - 1)) arb = 1'b1;
            else                                 gap_cnt_d = gap_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (arb) begin
         state_d = IDLE;
         if (|pending_q) begin
            sel_d   = prio_sel(pending_q);
            clr     = 4'b0001 << sel_d;
            state_d = EMIT;
         end
      end
      pending_d = (pending_q | press_set) & ~clr;
      drop_d    = |(press_set & pending_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         gap_cnt_q <= '0;
         pending_q <= '0;
         drop_q    <= 1'b0;
         sw1_q     <= '0;
         sw2_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         gap_cnt_q <= gap_cnt_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         sw1_q     <= sw_raw;
         sw2_q     <= sw1_q;
      end
   end

   assign pulse_vec    = (state_q == EMIT) ? (4'b0001 << sel_q) : 4'b0000;
   assign coin2_pulse  = pulse_vec[IDX_C2];
   assign coin5_pulse  = pulse_vec[IDX_C5];
   assign coin10_pulse = pulse_vec[IDX_C10];
   assign refund_pulse = pulse_vec[IDX_REF];
   assign sw_sync      = sw2_q;
   assign press_drop   = drop_q;
   assign busy         = (|pending_q) || (state_q != IDLE);

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed and random stimulus against two conditioner builds (gap 2 and gap 16),
// checked every cycle against an event-level reference model.
module tb_coin_input_conditioner;

   localparam int DEB  = 4;
   localparam int GAP_A = 2;
   localparam int GAP_B = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic [2:0] sw;

   logic [3:0] pulse_a, pulse_b;
   logic       drop_a, drop_b, busy_a, busy_b;
   logic [2:0] sws_a, sws_b;

   always #5 clk = ~clk;

   coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .PULSE_GAP(GAP_A)) u_dut_a (
      .clk           (clk),
      .rst           (rst),
      .btn2_raw      (btn[0]),
      .btn5_raw      (btn[1]),
      .btn10_raw     (btn[2]),
      .btnrefund_raw (btn[3]),
      .sw_raw        (sw),
      .coin2_pulse   (pulse_a[0]),
      .coin5_pulse   (pulse_a[1]),
      .coin10_pulse  (pulse_a[2]),
      .refund_pulse  (pulse_a[3]),
      .sw_sync       (sws_a),
      .press_drop    (drop_a),
      .busy          (busy_a)
   );

   coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .PULSE_GAP(GAP_B)) u_dut_b (
      .clk           (clk),
      .rst           (rst),
      .btn2_raw      (btn[0]),
      .btn5_raw      (btn[1]),
      .btn10_raw     (btn[2]),
      .btnrefund_raw (btn[3]),
      .sw_raw        (sw),
      .coin2_pulse   (pulse_b[0]),
      .coin5_pulse   (pulse_b[1]),
      .coin10_pulse  (pulse_b[2]),
      .refund_pulse  (pulse_b[3]),
      .sw_sync       (sws_b),
      .press_drop    (drop_b),
      .busy          (busy_b)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: raw history delayed two edges, a run length of
   // disagreeing samples per button, and per build a pending set plus the
   // earliest edge at which the next pulse may be issued.
   logic [3:0] m_s1, m_s2, m_stab;
   int         m_run [4];
   logic [2:0] m_sw1, m_sw2;
   logic [3:0] m_pend [2];
   logic [3:0] m_pulse [2];
   logic       m_drop [2];
   logic       m_busy [2];
   longint     m_free [2];
   int         m_gap [2];
   longint     m_edge = 0;
   int         refund_b_cnt = 0;
   int         pulse_cnt = 0;

   task automatic model_step();
      logic [3:0] rise;
      logic [3:0] clr;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_stab = '0; m_sw1 = '0; m_sw2 = '0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         for (int j = 0; j < 2; j++) begin
            m_pend[j] = '0; m_pulse[j] = '0; m_drop[j] = 1'b0;
            m_busy[j] = 1'b0; m_free[j] = 0;
         end
         m_edge++;
         return;
      end
      rise = '0;
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_stab[i]) begin
            if (m_run[i] == DEB - 1) begin
               m_stab[i] = m_s2[i];
               m_run[i]  = 0;
               rise[i]   = m_s2[i];
            end else begin
               m_run[i]++;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1; m_s1 = btn;
      m_sw2 = m_sw1; m_sw1 = sw;
      for (int j = 0; j < 2; j++) begin
         clr = '0;
         if (m_pend[j] != 0 && m_edge >= m_free[j]) begin
            for (int i = 0; i < 4; i++) begin
               if (m_pend[j][i]) begin
                  clr[i] = 1'b1;
                  break;
               end
            end
            m_free[j] = m_edge + 1 + m_gap[j];
         end
         m_pulse[j] = clr;
         m_drop[j]  = |(rise & m_pend[j] & ~clr);
         m_pend[j]  = (m_pend[j] | rise) & ~clr;
         m_busy[j]  = (m_pend[j] != 0) || (m_edge < m_free[j]);
      end
      m_edge++;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check("pulse_a", pulse_a, m_pulse[0]);
      check("drop_a",  drop_a,  m_drop[0]);
      check("busy_a",  busy_a,  m_busy[0]);
      check("sw_a",    sws_a,   m_sw2);
      check("pulse_b", pulse_b, m_pulse[1]);
      check("drop_b",  drop_b,  m_drop[1]);
      check("busy_b",  busy_b,  m_busy[1]);
      check("sw_b",    sws_b,   m_sw2);
      if (pulse_b[3]) refund_b_cnt++;
      pulse_cnt += $countones(pulse_a) + $countones(pulse_b);
   endtask

   task automatic drive(input logic [3:0] b, input int n);
      btn = b;
      repeat (n) cyc();
   endtask

   int hold [4];

   initial begin
      m_gap[0] = GAP_A;
      m_gap[1] = GAP_B;
      rst = 1'b1; btn = '0; sw = '0;
      repeat (2) cyc();
      rst = 1'b0;

      // Single press, short glitch, triple and coin+refund collisions.
      drive(4'b0001, 12); drive(4'b0000, 20);
      drive(4'b0010, 3);  drive(4'b0000, 15);
      drive(4'b0111, 10); drive(4'b0000, 25);
      drive(4'b1100, 10); drive(4'b0000, 60);

      // Refund re-pressed while still queued behind three coins in the gap-16 build.
      refund_b_cnt = 0;
      drive(4'b1111, 10); drive(4'b0111, 4); drive(4'b1111, 4);
      drive(4'b0000, 90);
      check("refund_b_total", refund_b_cnt, 1);

      // Reset one cycle after the first pulse discards the queue.
      sw = 3'b010;
      drive(4'b0111, 8);
      rst = 1'b1;
      drive(4'b0000, 1);
      rst = 1'b0;
      pulse_cnt = 0;
      drive(4'b0000, 40);
      check("pulses_after_rst", pulse_cnt, 0);
      check("sw_sync_hold", sws_a, 3'b010);

      for (int i = 0; i < 4; i++) hold[i] = 0;
      repeat (3000) begin
         for (int i = 0; i < 4; i++) begin
            if (hold[i] == 0) begin
               btn[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 12);
            end else begin
               hold[i]--;
            end
         end
         if ($urandom_range(0, 15) == 0) sw = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
Upstream front-end for vending_machine. It synchronizes and debounces the four raw board buttons: 2-coin, 5-coin, 10-coin and refund. Each debounced press becomes exactly one single-cycle pulse, and simultaneous presses are serialized so the FSM never sees two coin events in one cycle. The three product switches are passed through a 2-flop synchronizer only.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a button level is accepted (board build uses 1_000_000); min 2.
PULSE_GAP, 2, idle cycles forced after each emitted pulse; min 0.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
btn2_raw  in  1  raw 2-coin button (to BTNL side)
btn5_raw  in  1  raw 5-coin button (to BTNR side)
btn10_raw  in  1  raw 10-coin button (to BTND side)
btnrefund_raw  in  1  raw refund button (to BTNC side)
sw_raw  in  3  raw switches {women, men, child}
coin2_pulse  out  1  one-cycle accepted 2-coin event
coin5_pulse  out  1  one-cycle accepted 5-coin event
coin10_pulse  out  1  one-cycle accepted 10-coin event
refund_pulse  out  1  one-cycle refund event
sw_sync  out  3  synchronized switches
press_drop  out  1  one-cycle flag: press lost because its pending bit was already set
busy  out  1  high when any pending bit is set or state != IDLE

Behaviour:
- Reset: every flop is cleared, including sync stages, stable levels, counters, pending[3:0] and state. All outputs are 0. Reset mid-queue discards pending events; no pulse is emitted after rst deasserts unless a new press occurs.
- Sync: 2 flops per raw input. sw_sync = second stage.
- Debounce, per button:
  - If sync != stable, cnt++. When cnt == DEBOUNCE_CYCLES-1 and still differing, stable <= sync and cnt <= 0.
  - If sync == stable, cnt <= 0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press detect: on the same edge that stable goes 0->1, set pending[i]. If pending[i] is already set, assert press_drop for one cycle and keep a single pending bit. A release (1->0) generates no event.
- Pending indices: 0 = coin2, 1 = coin5, 2 = coin10, 3 = refund. Fixed priority coin2 > coin5 > coin10 > refund, so refund always follows coins already accepted.
- FSM states:
  - IDLE: if pending != 0, latch sel = highest-priority index, clear pending[sel] on that edge, go to EMIT.
  - EMIT: exactly one of the four pulses is high, decoded from the registered sel. Next state is GAP if PULSE_GAP > 0, else IDLE.
  - GAP: counts PULSE_GAP cycles, then returns to IDLE.
- A pending set and a pending clear for the same index on the same edge: the clear wins and press_drop is not asserted (the new press is the one being emitted).
- Latency, isolated press from IDLE, counting the edge that first samples raw high as edge 0:
  - stable and pending set at edge DEBOUNCE_CYCLES+1
  - pulse high for the single cycle after edge DEBOUNCE_CYCLES+2 (edge 6 for the default).
- Back-to-back pulse spacing is 1+PULSE_GAP cycles.
- Pulse outputs are registered, with no combinational path from raw inputs.

Decomposition:
- Package vm_pkg:
  - FSM state localparams (IDLE, EMIT, GAP, 2 bits)
  - pending index constants (IDX_C2 = 0, IDX_C5 = 1, IDX_C10 = 2, IDX_REF = 3)
  - coin value constants (2, 5, 10), shared with vending_machine
- Sub-module btn_debounce, parameterized on DEBOUNCE_CYCLES:
  - contains the 2-flop sync, counter and stable register, and outputs stable plus a rise strobe
  - instantiated four times
- Switch sync stays inline.

Test Plan:
1. btn2_raw high 12 cycles, defaults -> coin2_pulse high exactly the cycle after edge 6; all other pulses 0; busy high during edges 5–9.
2. btn5_raw high 3 cycles then low -> no pulse, press_drop 0, busy never asserted.
3. btn2_raw, btn5_raw and btn10_raw rise on the same edge and are held 10 cycles -> coin2, coin5, coin10 pulses on consecutive 3-cycle slots (edges 6, 9, 12); never two high together.
4. btn10_raw and btnrefund_raw rise together -> coin10_pulse first, refund_pulse 3 cycles later.
5. PULSE_GAP=16, all four buttons pressed together, then btnrefund_raw released and re-pressed (4 cycles each) while refund is still pending -> press_drop one cycle; exactly one refund_pulse total.
6. Three coins pending, rst asserted 1 cycle after the first pulse -> outputs 0 next edge; no further pulses over 40 cycles. sw_raw=3'b010 -> sw_sync=3'b010 two edges later.
